// File: rtl/brush_painter.sv
// brush_painter: turns paint/clear commands into one framebuffer write strobe per clock.
// Optional macro BRUSH_ROUND_EN restricts the paint stamp to a disc of radius r.
module brush_painter #(
    parameter int COORD_W = 7,
    parameter int RAD_W   = 2,
    parameter int COLOR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_clear,
    input  logic [COORD_W-1:0] cmd_x,
    input  logic [COORD_W-1:0] cmd_y,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic [RAD_W-1:0]   cmd_radius,
    output logic               brush,
    output logic [7:0]         wx,
    output logic [7:0]         wy,
    output logic [COLOR_W-1:0] newColor,
    output logic               busy
);
    localparam int D_W  = RAD_W + 2;
    localparam int P_W  = COORD_W + 2;
    localparam int SQ_W = 2 * D_W;
    localparam logic signed [D_W-1:0] ONE_D = D_W'(1);

    typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_e;

    state_e                 state_q, state_d;
    logic [COORD_W-1:0]     x_q, y_q;
    logic [COLOR_W-1:0]     color_q;
    logic [RAD_W-1:0]       r_q;
    logic signed [D_W-1:0]  dx_q, dy_q, dx_d, dy_d;
    logic [COORD_W-1:0]     cx_q, cy_q, cx_d, cy_d;
    logic                   brush_q, busy_q;
    logic [COORD_W-1:0]     wx_q, wy_q;
    logic [COLOR_W-1:0]     color_out_q;

    logic                   accept, step, last, wr_en, in_shape;
    logic [COORD_W-1:0]     sel_x, sel_y, cur_cx, cur_cy, wr_x, wr_y;
    logic [COLOR_W-1:0]     sel_color;
    logic [RAD_W-1:0]       sel_r;
    logic                   sel_clear;
    logic signed [D_W-1:0]  r_s, cur_dx, cur_dy;
    logic signed [P_W-1:0]  px, py;

    assign cmd_ready = (state_q == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign step      = accept || (state_q != IDLE);

    // The accept cycle itself emits the first strobe, so in IDLE the
    // command inputs stand in for the latched fields and iteration counters.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel_x     = x_q;
        sel_y     = y_q;
        sel_color = color_q;
        sel_r     = r_q;
        sel_clear = (state_q == CLEAR);
        cur_cx    = cx_q;
        cur_cy    = cy_q;
        if (state_q == IDLE) begin
            sel_x     = cmd_x;
            sel_y     = cmd_y;
            sel_color = cmd_color;
            sel_r     = cmd_radius;
            sel_clear = cmd_clear;
            cur_cx    = '0;
            cur_cy    = '0;
        end
        r_s    = $signed({2'b00, sel_r});
        cur_dx = (state_q == IDLE) ? -r_s : dx_q;
        cur_dy = (state_q == IDLE) ? -r_s : dy_q;

        px = $signed({2'b00, sel_x}) + P_W'(cur_dx);
        py = $signed({2'b00, sel_y}) + P_W'(cur_dy);

        if (cur_dx == r_s) begin
            dx_d = -r_s;
            dy_d = cur_dy + ONE_D;
        end else begin
            dx_d = cur_dx + ONE_D;
            dy_d = cur_dy;
        end
        cx_d = cur_cx + COORD_W'(1);
        cy_d = cur_cy + COORD_W'(&cur_cx);

        if (sel_clear) begin
            wr_en = 1'b1;
            wr_x  = cur_cx;
            wr_y  = cur_cy;
            last  = (&cur_cx) && (&cur_cy);
        end else begin
            // Negative or past-the-edge coordinates are dropped, never wrapped.
            wr_en = (px[P_W-1:COORD_W] == '0) && (py[P_W-1:COORD_W] == '0) && in_shape;
            wr_x  = px[COORD_W-1:0];
            wr_y  = py[COORD_W-1:0];
            last  = (cur_dx == r_s) && (cur_dy == r_s);
        end

        if (last)           state_d = IDLE;
        else if (sel_clear) state_d = CLEAR;
        else                state_d = PAINT;
    end

`ifdef BRUSH_ROUND_EN
    logic signed [SQ_W-1:0] dist_sq, rad_sq;
    always_comb begin
        dist_sq  = SQ_W'(cur_dx) * SQ_W'(cur_dx) + SQ_W'(cur_dy) * SQ_W'(cur_dy);
        rad_sq   = SQ_W'(r_s) * SQ_W'(r_s);
        in_shape = (dist_sq <= rad_sq);
    end
`else
    assign in_shape = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            brush_q     <= 1'b0;
            busy_q      <= 1'b0;
            wx_q        <= '0;
            wy_q        <= '0;
            color_out_q <= '0;
            x_q         <= '0;
            y_q         <= '0;
            color_q     <= '0;
            r_q         <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
        end else begin
            if (accept) begin
                x_q     <= cmd_x;
                y_q     <= cmd_y;
                color_q <= cmd_color;
                r_q     <= cmd_radius;
            end
            if (step) begin
                state_q <= state_d;
                busy_q  <= 1'b1;
                brush_q <= wr_en;
                if (wr_en) begin
                    wx_q        <= wr_x;
                    wy_q        <= wr_y;
                    color_out_q <= sel_color;
                end
                dx_q <= dx_d;
                dy_q <= dy_d;
                cx_q <= cx_d;
                cy_q <= cy_d;
            end else begin
                brush_q <= 1'b0;
                busy_q  <= 1'b0;
            end
        end
    end

    assign brush    = brush_q;
    assign busy     = busy_q;
    assign wx       = 8'(wx_q);
    assign wy       = 8'(wy_q);
    assign newColor = color_out_q;
endmodule

// File: tb/tb_brush_painter.sv
// Scoreboard bench for brush_painter: a model queues expected write strobes as
// commands are driven; a negedge monitor pops and compares every strobe the DUT emits.
module tb_brush_painter;
    localparam int COORD_W = 7;
    localparam int RAD_W   = 2;
    localparam int COLOR_W = 3;
    localparam int LIMIT   = 20000;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid, cmd_ready, cmd_clear;
    logic [COORD_W-1:0] cmd_x, cmd_y;
    logic [COLOR_W-1:0] cmd_color;
    logic [RAD_W-1:0]   cmd_radius;
    logic               brush, busy;
    logic [7:0]         wx, wy;
    logic [COLOR_W-1:0] newColor;

    brush_painter #(.COORD_W(COORD_W), .RAD_W(RAD_W), .COLOR_W(COLOR_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_clear(cmd_clear),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color), .cmd_radius(cmd_radius),
        .brush(brush), .wx(wx), .wy(wy), .newColor(newColor), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]         x;
        logic [7:0]         y;
        logic [COLOR_W-1:0] c;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_got, mon_exp;
    int  vectors = 0;
    int  miscompares = 0;
    int  writes_seen = 0;

    always @(negedge clk) begin
        if (brush === 1'b1) begin
            mon_got = {wx, wy, newColor};
            writes_seen++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL write_unexpected: got (%0d,%0d,c%0d), required no write",
                         wx, wy, newColor);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    miscompares++;
                    $display("FAIL write_order: got (%0d,%0d,c%0d), required (%0d,%0d,c%0d)",
                             mon_got.x, mon_got.y, mon_got.c, mon_exp.x, mon_exp.y, mon_exp.c);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: square stamp clipped to canvas; only the first max_cycles offsets count.
    task automatic push_paint(input int x, input int y, input int r, input int c, input int max_cycles);
        int cyc, px, py;
        bit hit;
        cyc = 0;
        for (int dy = -r; dy <= r; dy++) begin
            for (int dx = -r; dx <= r; dx++) begin
                cyc++;
                px  = x + dx;
                py  = y + dy;
                hit = (px >= 0) && (px < 128) && (py >= 0) && (py < 128);
`ifdef BRUSH_ROUND_EN
                if (dx * dx + dy * dy > r * r) hit = 1'b0;
`endif
                if (hit && cyc <= max_cycles) exp_q.push_back({8'(px), 8'(py), COLOR_W'(c)});
            end
        end
    endtask

    task automatic push_clear(input int c);
        for (int y = 0; y < 128; y++)
            for (int x = 0; x < 128; x++)
                exp_q.push_back({8'(x), 8'(y), COLOR_W'(c)});
    endtask

    task automatic drive_cmd(input bit clr, input int x, input int y, input int c, input int r);
        cmd_valid  = 1'b1;
        cmd_clear  = clr;
        cmd_x      = COORD_W'(x);
        cmd_y      = COORD_W'(y);
        cmd_color  = COLOR_W'(c);
        cmd_radius = RAD_W'(r);
    endtask

    // Drives a command and returns #1 after its accept edge (first strobe cycle).
    task automatic send(input bit clr, input int x, input int y, input int c, input int r);
        int n;
        n = 0;
        drive_cmd(clr, x, y, c, r);
        while (cmd_ready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: cmd_ready stayed %b, required 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < LIMIT) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        drive_cmd(1'b0, 0, 0, 0, 0);
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({brush, busy, wx, wy, newColor} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got brush=%b busy=%b wx=%0d wy=%0d color=%0d, required all 0",
                     brush, busy, wx, wy, newColor);
        end
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_low: got %b, required 0", cmd_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_single_pixel();
        push_paint(10, 20, 0, 3, LIMIT);
        send(1'b0, 10, 20, 3, 0);
        vectors++;
        if ({brush, wx, wy, newColor} !== {1'b1, 8'd10, 8'd20, 3'd3}) begin
            miscompares++;
            $display("FAIL r0_strobe: got brush=%b (%0d,%0d,c%0d), required brush=1 (10,20,c3)",
                     brush, wx, wy, newColor);
        end
        vectors++;
        if ({busy, cmd_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL r0_busy_ready: got busy=%b ready=%b, required 1 1", busy, cmd_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({brush, busy, wx, wy} !== {1'b0, 1'b0, 8'd10, 8'd20}) begin
            miscompares++;
            $display("FAIL r0_after: got brush=%b busy=%b (%0d,%0d), required 0 0 (10,20) held",
                     brush, busy, wx, wy);
        end
    endtask

    task automatic test_paint(input string name, input int x, input int y, input int c, input int r,
                              input int exp_busy, input int exp_writes);
        int n, w0;
        w0 = writes_seen;
        push_paint(x, y, r, c, LIMIT);
        send(1'b0, x, y, c, r);
        measure_busy(n);
        vectors++;
        if (n != exp_busy) begin
            miscompares++;
            $display("FAIL %s_busy_cycles: got %0d, required %0d", name, n, exp_busy);
        end
        vectors++;
        if (writes_seen - w0 != exp_writes) begin
            miscompares++;
            $display("FAIL %s_write_count: got %0d, required %0d", name, writes_seen - w0, exp_writes);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_missing_writes: got %0d pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_clear_then_paint();
        int n, w0;
        w0 = writes_seen;
        push_clear(0);
        push_paint(5, 5, 1, 6, LIMIT);
        send(1'b1, 0, 0, 0, 0);
        drive_cmd(1'b0, 5, 5, 6, 1);
        n = 1;
        while (cmd_ready !== 1'b1 && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (n != 16384) begin
            miscompares++;
            $display("FAIL clear_held_accept: ready in cycle %0d, required 16384", n);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        measure_busy(n);
        vectors++;
        if (n != 9) begin
            miscompares++;
            $display("FAIL b2b_paint_busy: got %0d, required 9", n);
        end
        vectors++;
        if (writes_seen - w0 != 16384 + 9) begin
            miscompares++;
            $display("FAIL clear_write_count: got %0d, required %0d", writes_seen - w0, 16384 + 9);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL clear_missing_writes: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_abort();
        int w0;
        w0 = writes_seen;
        push_paint(64, 64, 3, 4, 5);
        send(1'b0, 64, 64, 4, 3);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({brush, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_outputs: got brush=%b busy=%b, required 0 0", brush, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_ready: got %b, required 1", cmd_ready);
        end
        repeat (60) @(posedge clk);
        #1;
        vectors++;
        if (writes_seen - w0 != 5 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_write_count: got %0d writes %0d pending, required 5 writes 0 pending",
                     writes_seen - w0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_paint("square_r1", 64, 64, 2, 1, 9, 9);
        test_paint("edge_clip", 0, 127, 5, 2, 25, 9);
`ifdef BRUSH_ROUND_EN
        test_paint("round_r2", 64, 64, 1, 2, 25, 13);
`else
        test_paint("full_r2", 64, 64, 1, 2, 25, 25);
`endif
        test_clear_then_paint();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
